// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the
// 8-digit seven-segment driver, with saturation at 99_999_999 and leading-zero blanking.
module bin_to_bcd8 #(
   parameter int BIN_W    = 27,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [3:0]       d0,
   output logic [3:0]       d1,
   output logic [3:0]       d2,
   output logic [3:0]       d3,
   output logic [3:0]       d4,
   output logic [3:0]       d5,
   output logic [3:0]       d6,
   output logic [3:0]       d7
);

   localparam int          CNT_W     = $clog2(BIN_W + 1);
   localparam logic [31:0] DIG_RESET = BLANK_LZ ? 32'hFFFF_FFF0 : 32'h0000_0000;

   // Handshake: start is a request sampled on any edge where the FSM is IDLE; busy is
   // high from the accepting edge until done; done is a one-cycle result strobe.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [BIN_W-1:0]   shreg;
   logic [31:0]        acc;
   logic [31:0]        acc_adj;
   logic [31:0]        result;
   logic [31:0]        dig;
   logic [CNT_W-1:0]   cnt;
   logic               sat;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // Nibbles stay <= 9 between shifts, so the +3 never carries into the next nibble.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 8; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      logic lead;
      lead   = 1'b1;
      result = acc;
      if (sat) begin
         result = 32'h9999_9999;
      end else if (BLANK_LZ) begin
         for (int k = 7; k >= 1; k--) begin
            if (lead && (acc[4*k +: 4] == 4'd0)) result[4*k +: 4] = 4'hF;
            else                                 lead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         sat      <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         dig      <= DIG_RESET;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= bin_in;
                  acc   <= '0;
                  cnt   <= CNT_W'(BIN_W);
                  sat   <= (32'(bin_in) > 32'd99_999_999);
               end
            end
            SHIFT: begin
               {acc, shreg} <= {acc_adj, shreg} << 1;
               cnt          <= cnt - CNT_W'(1);
            end
            FINISH: begin
               done     <= 1'b1;
               overflow <= sat;
               dig      <= result;
            end
            default: ;
         endcase
      end
   end

   assign d0 = dig[3:0];
   assign d1 = dig[7:4];
   assign d2 = dig[11:8];
   assign d3 = dig[15:12];
   assign d4 = dig[19:16];
   assign d5 = dig[23:20];
   assign d6 = dig[27:24];
   assign d7 = dig[31:28];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Scoreboard bench for bin_to_bcd8: one blanking instance and one non-blanking instance,
// expected results computed from decimal arithmetic and checked on each done pulse.
module tb_bin_to_bcd8;

   localparam int BIN_W = 27;
   localparam int LAT   = BIN_W + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start1 = 1'b0, start2 = 1'b0;
   logic [BIN_W-1:0] bin1 = '0, bin2 = '0;
   logic             busy1, done1, ovf1, busy2, done2, ovf2;
   logic [3:0]       a0, a1, a2, a3, a4, a5, a6, a7;
   logic [3:0]       b0, b1, b2, b3, b4, b5, b6, b7;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int busy_cnt1 = 0;

   logic [32:0] exp_q1[$];
   logic [32:0] exp_q2[$];
   int          exp_c1[$];
   int          exp_c2[$];

   bin_to_bcd8 #(.BIN_W(BIN_W), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start1), .bin_in(bin1),
      .busy(busy1), .done(done1), .overflow(ovf1),
      .d0(a0), .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7)
   );

   bin_to_bcd8 #(.BIN_W(BIN_W), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .start(start2), .bin_in(bin2),
      .busy(busy2), .done(done2), .overflow(ovf2),
      .d0(b0), .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // reference model: {overflow, d7..d0}
   function automatic logic [32:0] model(int unsigned v, bit blank);
      logic [32:0] r;
      int unsigned p;
      if (v > 99_999_999) return {1'b1, 32'h9999_9999};
      r = '0;
      p = 1;
      for (int k = 0; k < 8; k++) begin
         if (blank && k > 0 && v < p) r[4*k +: 4] = 4'hF;
         else                         r[4*k +: 4] = 4'((v / p) % 10);
         if (k < 7) p = p * 10;
      end
      return r;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic issue1(int unsigned v);
      start1 = 1'b1;
      bin1   = BIN_W'(v);
      exp_q1.push_back(model(v, 1'b1));
      exp_c1.push_back(cyc + 1 + LAT);
      @(negedge clk);
      start1 = 1'b0;
      bin1   = BIN_W'($urandom);
   endtask

   task automatic convert1(int unsigned v);
      issue1(v);
      repeat (LAT) @(negedge clk);
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      exp_q1.delete(); exp_c1.delete();
      exp_q2.delete(); exp_c2.delete();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_dut", {busy1, done1, ovf1, a7, a6, a5, a4, a3, a2, a1, a0},
            {3'b000, 32'hFFFF_FFF0});
      check("rst_dut_nb", {busy2, done2, ovf2, b7, b6, b5, b4, b3, b2, b1, b0},
            {3'b000, 32'h0000_0000});
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt1 = 0;
      end else begin
         if (busy1) busy_cnt1++;
         if (done1) begin
            if (exp_q1.size() == 0) begin
               check("dut_unexpected_done", 1, 0);
            end else begin
               check("dut_result", {ovf1, a7, a6, a5, a4, a3, a2, a1, a0}, exp_q1.pop_front());
               check("dut_latency", cyc, exp_c1.pop_front());
               check("dut_busy_cycles", busy_cnt1, LAT);
            end
            busy_cnt1 = 0;
         end else if (exp_c1.size() > 0 && cyc > exp_c1[0]) begin
            check("dut_missing_done", 0, 1);
            void'(exp_q1.pop_front());
            void'(exp_c1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (done2) begin
            if (exp_q2.size() == 0) begin
               check("nb_unexpected_done", 1, 0);
            end else begin
               check("nb_result", {ovf2, b7, b6, b5, b4, b3, b2, b1, b0}, exp_q2.pop_front());
               check("nb_latency", cyc, exp_c2.pop_front());
            end
         end else if (exp_c2.size() > 0 && cyc > exp_c2[0]) begin
            check("nb_missing_done", 0, 1);
            void'(exp_q2.pop_front());
            void'(exp_c2.pop_front());
         end
      end
   end

   // stimulus
   initial begin
      int unsigned v;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_state();

      convert1(0);
      convert1(12_345_678);
      convert1(99_999_999);
      convert1(100_000_000);
      convert1(42);

      // start while busy must be ignored
      issue1(907);
      repeat (5) @(negedge clk);
      start1 = 1'b1;
      bin1   = BIN_W'(5);
      @(negedge clk);
      start1 = 1'b0;
      repeat (LAT) @(negedge clk);

      // reset in the middle of a conversion aborts it
      issue1(31_415_926);
      repeat (9) @(negedge clk);
      do_reset(2);
      check_reset_state();
      convert1(27_182_818);

      // back-to-back: each start lands in the previous done cycle
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 2 ** BIN_W - 1);
            1:       v = $urandom_range(100_000_000, 2 ** BIN_W - 1);
            2:       v = $urandom_range(0, 999);
            default: v = $urandom_range(0, 99_999_999);
         endcase
         convert1(v);
      end

      // non-blanking instance, then start held high for three conversions
      start2 = 1'b1;
      bin2   = BIN_W'(305);
      exp_q2.push_back(model(305, 1'b0));
      exp_c2.push_back(cyc + 1 + LAT);
      @(negedge clk);
      start2 = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      start2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v    = (i == 0) ? 0 : $urandom_range(0, 2 ** BIN_W - 1);
         bin2 = BIN_W'(v);
         exp_q2.push_back(model(v, 1'b0));
         exp_c2.push_back(cyc + 1 + LAT);
         repeat (BIN_W + 2) @(negedge clk);
      end
      start2 = 1'b0;

      repeat (LAT + 4) @(negedge clk);
      check("dut_pending", exp_q1.size(), 0);
      check("nb_pending", exp_q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
